// File: rtl/motion_sequencer.sv
// motion_sequencer
//   Command sequencer in front of one angle_to_step instance. Signed relative
//   moves are queued in a small FIFO, converted to magnitude plus direction,
//   and handed to the stepper one at a time. Between moves it enforces a
//   direction-setup gap before enable and a dwell gap after completion.
//   Supports a level-sensitive abort and a sticky stall fault.
//
//   Optional build macro POSITION_TRACK_EN adds position_o, a saturating
//   accumulator of the signed angles of all completed moves.
//
// Ports
//   clk_i           system clock
//   rst_ni          synchronous reset, active-low
//   cmd_valid_i     command offered
//   cmd_ready_o     FIFO not full
//   cmd_angle_i     signed relative angle, Q(SIZE/2).(SIZE/2)
//   abort_i         stop current move and flush queue (level)
//   busy_o          FSM not idle or FIFO non-empty
//   fault_o         sticky stall fault
//   level_o         FIFO occupancy
//   moves_done_o    completed-move counter, wraps
//   dir_o           1 = negative direction
//   mover_enable_o  to stepper enable
//   mover_angle_o   unsigned magnitude to stepper
//   mover_done_i    stepper done
//   position_o      (POSITION_TRACK_EN only) accumulated signed position
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a queued command
// SETUP | dir_o/magnitude latched, holding direction before enable
// START | enable high, waiting for the stepper to drop done
// RUN   | enable high, waiting for the stepper to raise done
// DWELL | enable low, gap before the next move
// FAULT | stepper never acknowledged; only reset leaves this state

module motion_sequencer #(
  parameter int SIZE             = 64,
  parameter int DEPTH            = 4,
  parameter int DIR_SETUP_CYCLES = 25,
  parameter int DWELL_CYCLES     = 250,
  parameter int BUSY_TIMEOUT     = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [SIZE-1:0]        cmd_angle_i,
  input  logic                   abort_i,
  output logic                   busy_o,
  output logic                   fault_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic [15:0]            moves_done_o,
  output logic                   dir_o,
  output logic                   mover_enable_o,
  output logic [SIZE-1:0]        mover_angle_o,
  input  logic                   mover_done_i
`ifdef POSITION_TRACK_EN
  ,
  output logic signed [SIZE-1:0] position_o
`endif
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int MAX_AB  = (DIR_SETUP_CYCLES > DWELL_CYCLES) ? DIR_SETUP_CYCLES : DWELL_CYCLES;
  localparam int TMR_MAX = (MAX_AB > BUSY_TIMEOUT) ? MAX_AB : BUSY_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(DIR_SETUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] START_LOAD = TMR_W'(BUSY_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] DWELL_LOAD = TMR_W'(DWELL_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_START,
    ST_RUN,
    ST_DWELL,
    ST_FAULT
  } state_t;

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;

  logic [SIZE-1:0]   fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q;

  logic              push, pop, flush, done_inc;
  logic [SIZE-1:0]   head, head_mag;
  logic              dir_q, enable_q;
  logic [SIZE-1:0]   mag_q;
  logic [15:0]       moves_q;

  // ---------------------------------------------------------------- FIFO
  assign cmd_ready_o = (level_q != LVL_W'(DEPTH));
  assign push        = cmd_valid_i && cmd_ready_o && !flush;
  assign head        = fifo_mem[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= cmd_angle_i;
  end

  // The most-negative angle has no positive counterpart; clamp it to the
  // largest positive magnitude instead of letting negation wrap.
  always_comb begin
    head_mag = head;
    if (head == {1'b1, {(SIZE-1){1'b0}}}) begin
      head_mag = {1'b0, {(SIZE-1){1'b1}}};
    end else if (head[SIZE-1]) begin
      head_mag = ~head + SIZE'(1);
    end
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    pop      = 1'b0;
    flush    = 1'b0;
    done_inc = 1'b0;
    if (abort_i && state_q != ST_FAULT) begin
      // Abort wins over every other event, including a completing move.
      state_d = ST_DWELL;
      tmr_d   = DWELL_LOAD;
      flush   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (level_q != '0) begin
            pop     = 1'b1;
            state_d = ST_SETUP;
            tmr_d   = SETUP_LOAD;
          end
        end
        ST_SETUP: begin
          if (mag_q == '0) begin
            state_d  = ST_DWELL;
            tmr_d    = DWELL_LOAD;
            done_inc = 1'b1;
          end else if (tmr_q == '0) begin
            state_d = ST_START;
            tmr_d   = START_LOAD;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
        ST_START: begin
          if (!mover_done_i) begin
            state_d = ST_RUN;
          end else if (tmr_q == '0) begin
            state_d = ST_FAULT;
            flush   = 1'b1;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
        ST_RUN: begin
          if (mover_done_i) begin
            state_d  = ST_DWELL;
            tmr_d    = DWELL_LOAD;
            done_inc = 1'b1;
          end
        end
        ST_DWELL: begin
          if (tmr_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------ output registers
  // Enable is registered from the next state so it is glitch-free and its
  // falling edge (which resets the stepper) lands exactly on the exit edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      dir_q    <= 1'b0;
      mag_q    <= '0;
      enable_q <= 1'b0;
      moves_q  <= '0;
    end else begin
      if (pop) begin
        dir_q <= head[SIZE-1];
        mag_q <= head_mag;
      end
      enable_q <= (state_d == ST_START) || (state_d == ST_RUN);
      if (done_inc) moves_q <= moves_q + 16'd1;
    end
  end

`ifdef POSITION_TRACK_EN
  logic signed [SIZE-1:0] angle_q, pos_q;
  logic        [SIZE:0]   pos_sum;

  assign pos_sum = {pos_q[SIZE-1], pos_q} + {angle_q[SIZE-1], angle_q};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      angle_q <= '0;
      pos_q   <= '0;
    end else begin
      if (pop) angle_q <= head;
      if (done_inc && state_q == ST_RUN) begin
        // Sign of the extended sum disagreeing with its top bit means overflow.
        if (pos_sum[SIZE] != pos_sum[SIZE-1]) begin
          pos_q <= pos_sum[SIZE] ? {1'b1, {(SIZE-1){1'b0}}} : {1'b0, {(SIZE-1){1'b1}}};
        end else begin
          pos_q <= pos_sum[SIZE-1:0];
        end
      end
    end
  end

  assign position_o = pos_q;
`endif

  assign busy_o         = (state_q != ST_IDLE) || (level_q != '0);
  assign fault_o        = (state_q == ST_FAULT);
  assign level_o        = level_q;
  assign moves_done_o   = moves_q;
  assign dir_o          = dir_q;
  assign mover_enable_o = enable_q;
  assign mover_angle_o  = mag_q;

endmodule

// File: tb/tb_motion_sequencer.sv
// Testbench for motion_sequencer. The reference model tracks the command
// queue and, for each popped move, the absolute cycle numbers at which
// enable rises, the move completes and the sequencer becomes idle again.
// The stepper's done line is driven from that same per-move schedule.
module tb_motion_sequencer;

  localparam int     SIZE       = 64;
  localparam int     DEPTH      = 4;
  localparam int     DIR_SETUP  = 25;
  localparam int     DWELL      = 250;
  localparam int     BUSY_TO    = 16;
  localparam int     WAIT_LIMIT = 5000;
  localparam longint MIN_ANGLE  = 64'sh8000_0000_0000_0000;
  localparam longint MAX_ANGLE  = 64'sh7fff_ffff_ffff_ffff;

  logic                   clk_i       = 1'b0;
  logic                   rst_ni      = 1'b0;
  logic                   cmd_valid_i = 1'b0;
  logic                   cmd_ready_o;
  logic [SIZE-1:0]        cmd_angle_i = '0;
  logic                   abort_i     = 1'b0;
  logic                   busy_o;
  logic                   fault_o;
  logic [$clog2(DEPTH):0] level_o;
  logic [15:0]            moves_done_o;
  logic                   dir_o;
  logic                   mover_enable_o;
  logic [SIZE-1:0]        mover_angle_o;
  logic                   mover_done_i = 1'b1;
`ifdef POSITION_TRACK_EN
  logic signed [SIZE-1:0] position_o;
`endif

  motion_sequencer dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_angle_i    (cmd_angle_i),
    .abort_i        (abort_i),
    .busy_o         (busy_o),
    .fault_o        (fault_o),
    .level_o        (level_o),
    .moves_done_o   (moves_done_o),
    .dir_o          (dir_o),
    .mover_enable_o (mover_enable_o),
    .mover_angle_o  (mover_angle_o),
`ifdef POSITION_TRACK_EN
    .position_o     (position_o),
`endif
    .mover_done_i   (mover_done_i)
  );

  always #5 clk_i = ~clk_i;

  int          vectors;
  int          miscompares;
  longint      n;
  longint      q[$];
  bit          active, nz, faulted, last_acc;
  longint      s_t, d_t, t_idle, cur_l, cur_r, cur_angle, exp_pos;
  logic        exp_dir;
  logic [63:0] exp_mag;
  logic [15:0] exp_cnt;
  int          force_l, force_r;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, n, got, exp);
    end
  endtask

  function automatic logic [63:0] mag_of(input longint a);
    if (a == MIN_ANGLE) return MAX_ANGLE;
    if (a < 0) return -a;
    return a;
  endfunction

  function automatic longint sat_add(input longint a, input longint b);
    if (b > 0 && a > MAX_ANGLE - b) return MAX_ANGLE;
    if (b < 0 && a < MIN_ANGLE - b) return MIN_ANGLE;
    return a + b;
  endfunction

  task automatic model_reset();
    q.delete();
    active  = 0;
    nz      = 0;
    faulted = 0;
    t_idle  = 0;
    exp_cnt = '0;
    exp_dir = 1'b0;
    exp_mag = '0;
    exp_pos = 0;
  endtask

  task automatic check_outputs();
    bit en_exp;
    en_exp = active && nz && n >= s_t && n < d_t;
    check_val("cmd_ready",  cmd_ready_o,    q.size() < DEPTH);
    check_val("level",      level_o,        q.size());
    check_val("busy",       busy_o,         faulted || active || n < t_idle || q.size() != 0);
    check_val("fault",      fault_o,        faulted);
    check_val("moves_done", moves_done_o,   exp_cnt);
    check_val("dir",        dir_o,          exp_dir);
    check_val("enable",     mover_enable_o, en_exp);
    check_val("mag",        mover_angle_o,  exp_mag);
`ifdef POSITION_TRACK_EN
    check_val("position",   position_o,     exp_pos);
`endif
  endtask

  // One clock: drive done from the schedule, advance the model by one edge,
  // then compare every output.
  task automatic cycle();
    longint m;
    int     sz;
    bit     idle_n, acc;
    m = n + 1;
    mover_done_i = !(active && nz && m >= s_t + cur_l && m < s_t + cur_l + cur_r);
    sz     = q.size();
    idle_n = !faulted && !active && n >= t_idle;
    acc    = 0;
    @(posedge clk_i);
    #1;
    if (!rst_ni) begin
      model_reset();
    end else if (faulted) begin
      acc = cmd_valid_i && sz < DEPTH;
      if (acc) q.push_back($signed(cmd_angle_i));
    end else if (abort_i) begin
      q.delete();
      active = 0;
      t_idle = m + DWELL;
    end else if (active && nz && cur_l > BUSY_TO && m == s_t + BUSY_TO) begin
      faulted = 1;
      active  = 0;
      q.delete();
    end else begin
      if (active && m == d_t) begin
        exp_cnt = exp_cnt + 16'd1;
        if (nz) exp_pos = sat_add(exp_pos, cur_angle);
        active = 0;
      end
      acc = cmd_valid_i && sz < DEPTH;
      if (idle_n && sz > 0) begin
        cur_angle = q.pop_front();
        exp_dir   = cur_angle < 0;
        exp_mag   = mag_of(cur_angle);
        nz        = cur_angle != 0;
        active    = 1;
        s_t       = m + DIR_SETUP;
        cur_l     = (force_l != 0) ? force_l : $urandom_range(1, BUSY_TO);
        cur_r     = (force_r != 0) ? force_r : $urandom_range(1, 20);
        d_t       = nz ? s_t + cur_l + cur_r : m + 1;
        t_idle    = d_t + DWELL;
      end
      if (acc) q.push_back($signed(cmd_angle_i));
    end
    last_acc = acc;
    n = m;
    check_outputs();
  endtask

  task automatic idle_cycles(input int k);
    cmd_valid_i = 1'b0;
    repeat (k) cycle();
  endtask

  task automatic push_cmd(input longint a);
    int tries;
    tries = 0;
    cmd_valid_i = 1'b1;
    cmd_angle_i = a;
    do begin
      cycle();
      tries++;
    end while (!last_acc && tries < WAIT_LIMIT);
    cmd_valid_i = 1'b0;
    check_val("push_accept", last_acc, 1);
  endtask

  task automatic wait_idle();
    int tries;
    tries = 0;
    cmd_valid_i = 1'b0;
    while ((active || n < t_idle || q.size() != 0) && tries < WAIT_LIMIT) begin
      cycle();
      tries++;
    end
    check_val("idle_reached", busy_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int     tries;
    longint a;
    n = 0;
    model_reset();

    // reset
    rst_ni = 1'b0;
    idle_cycles(3);
    rst_ni = 1'b1;
    idle_cycles(2);

    // +90.0 then -45.5, single moves
    force_l = 3; force_r = 5;
    push_cmd(longint'(90) << 32);
    wait_idle();
    force_l = 0; force_r = 0;
    push_cmd(-(longint'(91) << 31));
    wait_idle();

    // five back-to-back with one move already in flight
    push_cmd(longint'(10) << 32);
    idle_cycles(2);
    push_cmd(longint'(20) << 32);
    push_cmd(-(longint'(30) << 32));
    push_cmd(longint'(40) << 32);
    push_cmd(-(longint'(50) << 32));
    check_val("full_ready", cmd_ready_o, 0);
    push_cmd(longint'(60) << 32);
    wait_idle();

    // abort mid-RUN with three queued
    force_r = 60;
    push_cmd(longint'(1) << 32);
    push_cmd(longint'(2) << 32);
    push_cmd(longint'(3) << 32);
    push_cmd(longint'(4) << 32);
    tries = 0;
    while (!(active && n >= s_t + cur_l + 2) && tries < WAIT_LIMIT) begin
      cycle();
      tries++;
    end
    abort_i = 1'b1;
    cycle();
    abort_i = 1'b0;
    force_r = 0;
    wait_idle();

    // zero angle, then most-negative with done falling on the last allowed cycle
    push_cmd(0);
    wait_idle();
    force_l = BUSY_TO;
    push_cmd(MIN_ANGLE);
    wait_idle();
    force_l = 0;

    // randomized traffic with occasional aborts
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 9))
        0: a = 0;
        1: a = MIN_ANGLE;
        2: a = MAX_ANGLE;
        3, 4, 5: begin
          a = longint'($urandom_range(1, 360)) << 32;
          if ($urandom_range(0, 1) == 1) a = -a;
        end
        default: a = longint'({$urandom(), $urandom()});
      endcase
      push_cmd(a);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(0, 30));
      if ($urandom_range(0, 11) == 0) begin
        idle_cycles($urandom_range(0, 60));
        abort_i = 1'b1;
        repeat ($urandom_range(1, 3)) cycle();
        abort_i = 1'b0;
      end
    end
    wait_idle();

    // stall fault: done never falls
    force_l = 1000;
    push_cmd(longint'(90) << 32);
    tries = 0;
    while (!faulted && tries < WAIT_LIMIT) begin
      cycle();
      tries++;
    end
    check_val("fault_set", fault_o, 1);
    force_l = 0;
    push_cmd(longint'(10) << 32);
    push_cmd(-(longint'(3) << 32));
    idle_cycles(400);
    rst_ni = 1'b0;
    idle_cycles(2);
    rst_ni = 1'b1;
    check_val("fault_cleared", fault_o, 0);
    push_cmd(longint'(1) << 32);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
